// File: rtl/mem_wb_pipe_pkg.sv
// mem_wb_pipe_pkg: shared types and constants for the MEM->WB stage.
// Payload layout, zero payload and occupancy state encodings.
package mem_wb_pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEST_W_DEF = 4;

    typedef struct packed {
        logic                  wb_en;
        logic                  mem_r_en;
        logic [DATA_W_DEF-1:0] alu_result;
        logic [DATA_W_DEF-1:0] mem_data;
        logic [DEST_W_DEF-1:0] dest;
    } payload_t;

    localparam payload_t PAYLOAD_ZERO = '0;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // Flat payload width for a given data/dest width.
    function automatic int payload_w(input int dw, input int tw);
        return 2 + 2 * dw + tw;
    endfunction

endpackage

// File: rtl/mem_wb_pipe_slot.sv
// pipe_slot: one valid bit plus payload register.
// rst zeroes everything; clear kills valid only; load captures d.
module pipe_slot
    import mem_wb_pipe_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    // Slot register: rst beats clear, clear beats load.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: MEM->WB stage with valid/ready and 2-entry skid.
// Main slot drives outputs; skid only absorbs a stalled write-back.
module mem_wb_pipe
    import mem_wb_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wb_en,
    input  logic              in_mem_r_en,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [DEST_W-1:0] in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_wb_en,
    output logic              out_mem_r_en,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_mem_data,
    output logic [DEST_W-1:0] out_dest,
    output logic [DATA_W-1:0] out_wb_value,
    output logic [1:0]        fwd_valid,
    output logic [DEST_W-1:0] fwd_dest0,
    output logic [DEST_W-1:0] fwd_dest1,
    output logic [1:0]        occupancy
);

    localparam int PW = payload_w(DATA_W, DEST_W);
    localparam int AH = PW - 3;
    localparam int MH = DEST_W + DATA_W - 1;

    logic [PW-1:0] in_pl;
    logic [PW-1:0] main_q;
    logic [PW-1:0] skid_q;
    logic [PW-1:0] main_d;
    logic          main_v;
    logic          skid_v;
    logic          main_ld;
    logic          main_clr;
    logic          skid_ld;
    logic          skid_clr;
    logic          accept;
    logic          drain;
    logic [1:0]    state;

    assign in_pl = {in_wb_en, in_mem_r_en, in_alu_result,
                    in_mem_data, in_dest};

    assign in_ready = ~skid_v;
    assign accept   = in_valid & in_ready;
    assign drain    = main_v & out_ready;

    assign state = skid_v ? ST_FULL : (main_v ? ST_ONE : ST_EMPTY);
    assign occupancy = state;

    // Occupancy FSM: choose slot loads/clears for this edge.
    always_comb begin
        main_ld  = 1'b0;
        main_clr = 1'b0;
        skid_ld  = 1'b0;
        skid_clr = 1'b0;
        main_d   = in_pl;
        unique case (state)
            ST_EMPTY: begin
                main_ld = accept;
            end
            ST_ONE: begin
                if (accept && drain) begin
                    main_ld = 1'b1;
                end else if (accept) begin
                    skid_ld = 1'b1;
                end else if (drain) begin
                    main_clr = 1'b1;
                end
            end
            ST_FULL: begin
                if (drain) begin
                    main_ld  = 1'b1;
                    main_d   = skid_q;
                    skid_clr = 1'b1;
                end
            end
            default: begin
                main_clr = 1'b1;
                skid_clr = 1'b1;
            end
        endcase
        if (flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end
    end

    pipe_slot #(.W(PW)) u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_ld),
        .clear (main_clr),
        .d     (main_d),
        .valid (main_v),
        .q     (main_q)
    );

    pipe_slot #(.W(PW)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_ld),
        .clear (skid_clr),
        .d     (in_pl),
        .valid (skid_v),
        .q     (skid_q)
    );

    assign out_valid      = main_v;
    assign out_wb_en      = main_q[PW-1] & main_v;
    assign out_mem_r_en   = main_q[PW-2];
    assign out_alu_result = main_q[AH -: DATA_W];
    assign out_mem_data   = main_q[MH -: DATA_W];
    assign out_dest       = main_q[DEST_W-1:0];
    assign out_wb_value   = out_mem_r_en ? out_mem_data
                                         : out_alu_result;

    assign fwd_valid = {skid_v & skid_q[PW-1], out_wb_en};
    assign fwd_dest0 = main_q[DEST_W-1:0];
    assign fwd_dest1 = skid_q[DEST_W-1:0];

endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb_mem_wb_pipe: directed self-checking bench for mem_wb_pipe.
// Inputs change #1 after posedge; checks follow each tick.
module tb_mem_wb_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_wb_en;
    logic        in_mem_r_en;
    logic [31:0] in_alu_result;
    logic [31:0] in_mem_data;
    logic [3:0]  in_dest;
    logic        out_valid;
    logic        out_ready;
    logic        out_wb_en;
    logic        out_mem_r_en;
    logic [31:0] out_alu_result;
    logic [31:0] out_mem_data;
    logic [3:0]  out_dest;
    logic [31:0] out_wb_value;
    logic [1:0]  fwd_valid;
    logic [3:0]  fwd_dest0;
    logic [3:0]  fwd_dest1;
    logic [1:0]  occupancy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_wb_pipe #(.DATA_W(32), .DEST_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_wb_en       (in_wb_en),
        .in_mem_r_en    (in_mem_r_en),
        .in_alu_result  (in_alu_result),
        .in_mem_data    (in_mem_data),
        .in_dest        (in_dest),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_wb_en      (out_wb_en),
        .out_mem_r_en   (out_mem_r_en),
        .out_alu_result (out_alu_result),
        .out_mem_data   (out_mem_data),
        .out_dest       (out_dest),
        .out_wb_value   (out_wb_value),
        .fwd_valid      (fwd_valid),
        .fwd_dest0      (fwd_dest0),
        .fwd_dest1      (fwd_dest1),
        .occupancy      (occupancy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic wb,
                         input logic mr, input logic [31:0] alu,
                         input logic [31:0] md,
                         input logic [3:0] d);
        in_valid      = v;
        in_wb_en      = wb;
        in_mem_r_en   = mr;
        in_alu_result = alu;
        in_mem_data   = md;
        in_dest       = d;
    endtask

    initial begin
        // Reset with random inputs.
        rst   = 1'b1;
        flush = $urandom_range(1);
        out_ready = $urandom_range(1);
        drive(1'b1, 1'b1, 1'b1, $urandom, $urandom, 4'hF);
        repeat (3) tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_occ", occupancy, 0);
        chk("rst_alu", out_alu_result, 0);
        chk("rst_mem", out_mem_data, 0);
        chk("rst_dest", out_dest, 0);
        chk("rst_wb_value", out_wb_value, 0);
        chk("rst_wb_en", out_wb_en, 0);
        chk("rst_fwd", fwd_valid, 0);

        // Streaming, one per cycle.
        rst = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h10 + i, 32'h0,
                  4'(i + 1));
            tick();
            chk("str_dest", out_dest, i + 1);
            chk("str_alu", out_alu_result, 32'h10 + i);
            chk("str_occ", occupancy, 1);
            chk("str_wb_en", out_wb_en, 1);
        end
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
        tick();
        chk("str_drained", occupancy, 0);

        // Stall fills skid.
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'hA, 0, 4'd5);
        tick();
        chk("stl_occ1", occupancy, 1);
        drive(1'b1, 1'b1, 1'b0, 32'hB, 0, 4'd6);
        tick();
        chk("stl_occ2", occupancy, 2);
        chk("stl_in_ready", in_ready, 0);
        chk("stl_fwd", fwd_valid, 2'b11);
        chk("stl_fdest0", fwd_dest0, 5);
        chk("stl_fdest1", fwd_dest1, 6);
        drive(1'b1, 1'b1, 1'b0, 32'hC, 0, 4'd7);
        tick();
        chk("stl_hold", out_dest, 5);
        chk("stl_hold_occ", occupancy, 2);
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
        out_ready = 1'b1;
        #1;
        chk("stl_a_out", out_alu_result, 32'hA);
        tick();
        chk("stl_b_dest", out_dest, 6);
        chk("stl_b_alu", out_alu_result, 32'hB);
        chk("stl_b_occ", occupancy, 1);
        tick();
        chk("stl_empty", occupancy, 0);

        // Load vs ALU select.
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 32'h4, 32'hDEADBEEF, 4'd7);
        tick();
        chk("sel_load", out_wb_value, 32'hDEADBEEF);
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h4, 32'hDEADBEEF, 4'd7);
        tick();
        chk("sel_alu", out_wb_value, 32'h4);
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
        tick();
        chk("sel_empty", occupancy, 0);

        // Flush in FULL with an incoming payload.
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h20, 0, 4'd8);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h21, 0, 4'd9);
        tick();
        chk("fl_full", occupancy, 2);
        flush = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h22, 0, 4'd10);
        tick();
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
        chk("fl_occ", occupancy, 0);
        chk("fl_valid", out_valid, 0);
        chk("fl_wb_en", out_wb_en, 0);
        chk("fl_fwd", fwd_valid, 0);
        chk("fl_in_ready", in_ready, 1);
        tick();
        chk("fl_nothing", out_valid, 0);

        // Accept + drain in ONE for 10 cycles.
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h100, 0, 4'd0);
        tick();
        chk("ad_first", out_alu_result, 32'h100);
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h100 + i, 0, 4'(i));
            tick();
            chk("ad_occ", occupancy, 1);
            chk("ad_alu", out_alu_result, 32'h100 + i);
            chk("ad_dest", out_dest, i);
        end
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
        tick();
        chk("ad_empty", occupancy, 0);

        // Reset mid-stall discards both entries.
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h55, 32'h66, 4'd3);
        tick();
        tick();
        chk("rs_full", occupancy, 2);
        rst = 1'b1;
        flush = 1'b1;
        tick();
        rst = 1'b0;
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
        chk("rs_occ", occupancy, 0);
        chk("rs_alu", out_alu_result, 0);
        chk("rs_fdest1", fwd_dest1, 0);
        chk("rs_in_ready", in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
